// File: rtl/pe_pkg.sv
// pe_pkg: constants and types shared by the PE row feeder and its bench.
//   PIX_W  - pixel width
//   WGT_W  - per-tap weight width
//   TAPS   - taps per filter word (the PE is built for exactly 3)
//   PSUM_W - width of the PE partial-sum output
//   flt_word_t - one packed filter word, tap0 in the low WGT_W bits
//   state_t    - feeder FSM states
package pe_pkg;
  localparam int PIX_W  = 8;
  localparam int WGT_W  = 4;
  localparam int TAPS   = 3;
  localparam int PSUM_W = 14;

  typedef logic [TAPS*WGT_W-1:0] flt_word_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_FLT = 3'd1,
    STREAM   = 3'd2,
    DRAIN    = 3'd3,
    FIN      = 3'd4
  } state_t;
endpackage

// File: rtl/pe_row_feeder_if.sv
// pe_row_feeder_if: upstream filter/pixel streams plus the PE-side outputs
// of the row feeder.
//   flt_valid/flt_data/flt_ready : filter word stream (tap0 in low bits)
//   pix_valid/pix_data/pix_ready : pixel stream
//   pe_en/pe_filtr/pe_ifmap      : PE enable, filter and pixel-shift inputs
//   pe_psum_valid/pe_psum_last   : tags aligned with the PE psum output
// Modports: slave = the feeder, master = the environment around it.
//
// Handshake: a word moves on a rising clock edge where valid and ready are
// both high. A source holds valid and data stable until that edge; ready may
// rise or fall freely and never depends combinationally on valid.
interface pe_row_feeder_if #(
  parameter int PIX_W = pe_pkg::PIX_W,
  parameter int WGT_W = pe_pkg::WGT_W,
  parameter int TAPS  = pe_pkg::TAPS
);
  logic                   flt_valid;
  logic [TAPS*WGT_W-1:0]  flt_data;
  logic                   flt_ready;
  logic                   pix_valid;
  logic [PIX_W-1:0]       pix_data;
  logic                   pix_ready;
  logic                   pe_en;
  logic [TAPS*WGT_W-1:0]  pe_filtr;
  logic [PIX_W-1:0]       pe_ifmap;
  logic                   pe_psum_valid;
  logic                   pe_psum_last;

  modport slave (
    input  flt_valid, flt_data, pix_valid, pix_data,
    output flt_ready, pix_ready, pe_en, pe_filtr, pe_ifmap,
           pe_psum_valid, pe_psum_last
  );

  modport master (
    output flt_valid, flt_data, pix_valid, pix_data,
    input  flt_ready, pix_ready, pe_en, pe_filtr, pe_ifmap,
           pe_psum_valid, pe_psum_last
  );
endinterface

// File: rtl/pe_feed_fifo.sv
// pe_feed_fifo: synchronous first-word-fall-through FIFO for row pixels.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push, din  : write request and data; accepted when not full, or when
//                full and popped in the same cycle
//   pop        : removes the head; ignored when empty
//   dout       : current head (valid whenever empty is low)
//   full/empty : occupancy flags
module pe_feed_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // On a full push+pop the write lands in the slot being read; the head has
  // already been consumed combinationally this cycle, so that is safe.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pe_row_feeder.sv
// pe_row_feeder: feeds one PE with a 3-tap filter word and a row of pixels,
// one pixel per enabled cycle, and tags the PE psum output so a downstream
// collector knows which cycles hold complete windows.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begins a row (ignored unless idle)
//   busy       : FSM not idle
//   done       : one-cycle pulse the cycle after the final psum tag
//   dbg_state  : current FSM state
//   bus        : filter/pixel streams in, PE drive and psum tags out
// Optional build macro PE_FEEDER_ZERO_PAD_EN: inject one zero pixel before
// and after the row ("same" padding, ROW_LEN valid psums). Without it the
// row is a "valid" convolution with ROW_LEN-TAPS+1 valid psums.
module pe_row_feeder
  import pe_pkg::*;
#(
  parameter int ROW_LEN    = 16,
  parameter int PIX_W      = pe_pkg::PIX_W,
  parameter int WGT_W      = pe_pkg::WGT_W,
  parameter int TAPS       = pe_pkg::TAPS,
  parameter int FIFO_DEPTH = 8,
  parameter int PE_LAT     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state,
  pe_row_feeder_if.slave       bus
);
  if (TAPS != 3) begin : g_bad_taps
    $error("pe_row_feeder: TAPS must be 3");
  end
  if (ROW_LEN < TAPS || ROW_LEN > 255) begin : g_bad_row_len
    $error("pe_row_feeder: ROW_LEN out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pe_row_feeder: FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (PE_LAT < 1) begin : g_bad_lat
    $error("pe_row_feeder: PE_LAT must be at least 1");
  end

  localparam logic [7:0] ROW_LEN_C  = 8'(ROW_LEN);
  localparam logic [7:0] LAST_DRAIN = 8'(PE_LAT - 1);
`ifdef PE_FEEDER_ZERO_PAD_EN
  // Pixel i is PE input i+1, so its window completes from i = TAPS-2.
  localparam logic [7:0] TAG_FIRST  = 8'(TAPS - 2);
  localparam logic [7:0] LAST_VALID = 8'(ROW_LEN - 1);
`else
  localparam logic [7:0] TAG_FIRST  = 8'(TAPS - 1);
  localparam logic [7:0] LAST_VALID = 8'(ROW_LEN - TAPS);
  localparam logic [7:0] LAST_PIX   = 8'(ROW_LEN - 1);
`endif

  state_t                state_q, state_d;
  logic [7:0]            acc_cnt_q, sent_cnt_q, drain_cnt_q, psum_cnt_q;
  logic [PE_LAT:0]       tag_sr_q;
  logic                  pe_en_q, done_q;
  logic [PIX_W-1:0]      pe_ifmap_q;
  logic [TAPS*WGT_W-1:0] pe_filtr_q;
`ifdef PE_FEEDER_ZERO_PAD_EN
  logic                  pad_pre_q;
`endif

  logic                  fifo_full, fifo_empty;
  logic [PIX_W-1:0]      fifo_dout;
  logic                  push, pop, pix_ready;
  logic                  issue, issue_tag;
  logic [PIX_W-1:0]      issue_pix;
  logic                  psum_valid;

  pe_feed_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.pix_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full FIFO still accepts when it pops the same cycle; pop never depends
  // on pix_valid, so there is no combinational path from valid to ready.
  assign pix_ready = ((state_q == LOAD_FLT) || (state_q == STREAM)) &&
                     (acc_cnt_q != ROW_LEN_C) && (!fifo_full || pop);
  assign push      = bus.pix_valid && pix_ready;

  // issue = drive one PE input this cycle (pixel, pad zero or flush zero).
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    pop       = 1'b0;
    issue_pix = '0;
    issue_tag = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = LOAD_FLT;
      LOAD_FLT: if (bus.flt_valid) state_d = STREAM;
      STREAM: begin
`ifdef PE_FEEDER_ZERO_PAD_EN
        if (!pad_pre_q) begin
          issue = 1'b1;
        end else if (sent_cnt_q != ROW_LEN_C) begin
          if (!fifo_empty) begin
            issue     = 1'b1;
            pop       = 1'b1;
            issue_pix = fifo_dout;
            issue_tag = (sent_cnt_q >= TAG_FIRST);
          end
        end else begin
          // Trailing pad completes the last window.
          issue     = 1'b1;
          issue_tag = 1'b1;
          state_d   = DRAIN;
        end
`else
        if (!fifo_empty) begin
          issue     = 1'b1;
          pop       = 1'b1;
          issue_pix = fifo_dout;
          issue_tag = (sent_cnt_q >= TAG_FIRST);
          if (sent_cnt_q == LAST_PIX) state_d = DRAIN;
        end
`endif
      end
      DRAIN: begin
        issue = 1'b1;
        if (drain_cnt_q == LAST_DRAIN) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q   <= '0;
      sent_cnt_q  <= '0;
      drain_cnt_q <= '0;
      psum_cnt_q  <= '0;
      tag_sr_q    <= '0;
      pe_en_q     <= 1'b0;
      pe_ifmap_q  <= '0;
      pe_filtr_q  <= '0;
      done_q      <= 1'b0;
`ifdef PE_FEEDER_ZERO_PAD_EN
      pad_pre_q   <= 1'b0;
`endif
    end else begin
      pe_en_q <= issue;
      done_q  <= (state_q == FIN);
      // pe_ifmap holds across stalls so the frozen PE sees no change.
      if (issue) pe_ifmap_q <= issue_pix;
      if (state_q == LOAD_FLT && bus.flt_valid) pe_filtr_q <= bus.flt_data;
      if (state_q == IDLE) begin
        acc_cnt_q   <= '0;
        sent_cnt_q  <= '0;
        drain_cnt_q <= '0;
        psum_cnt_q  <= '0;
        tag_sr_q    <= '0;
`ifdef PE_FEEDER_ZERO_PAD_EN
        pad_pre_q   <= 1'b0;
`endif
      end else begin
        if (push)               acc_cnt_q   <= acc_cnt_q + 8'd1;
        if (pop)                sent_cnt_q  <= sent_cnt_q + 8'd1;
        if (state_q == DRAIN)   drain_cnt_q <= drain_cnt_q + 8'd1;
        if (psum_valid)         psum_cnt_q  <= psum_cnt_q + 8'd1;
        // Tags advance only with enabled PE cycles, like the PE pipeline.
        if (issue)              tag_sr_q    <= {tag_sr_q[PE_LAT-1:0], issue_tag};
`ifdef PE_FEEDER_ZERO_PAD_EN
        if (state_q == STREAM && issue) pad_pre_q <= 1'b1;
`endif
      end
    end
  end

  assign psum_valid = pe_en_q && tag_sr_q[PE_LAT];

  assign busy              = (state_q != IDLE);
  assign done              = done_q;
  assign dbg_state         = state_q;
  assign bus.flt_ready     = (state_q == LOAD_FLT);
  assign bus.pix_ready     = pix_ready;
  assign bus.pe_en         = pe_en_q;
  assign bus.pe_filtr      = pe_filtr_q;
  assign bus.pe_ifmap      = pe_ifmap_q;
  assign bus.pe_psum_valid = psum_valid;
  assign bus.pe_psum_last  = psum_valid && (psum_cnt_q == LAST_VALID);
endmodule

// File: tb/tb_pe_row_feeder.sv
// tb_pe_row_feeder: directed bench for pe_row_feeder (ROW_LEN=16, PE_LAT=1).
// Each row pushes its expected PE beats ({pe_filtr, pe_ifmap, psum_valid,
// psum_last}) into exp_q; the negedge monitor pops one per pe_en cycle.
module tb_pe_row_feeder;
  import pe_pkg::*;

  localparam int ROW = 16;
  localparam int EW  = TAPS*WGT_W + PIX_W + 2;
`ifdef PE_FEEDER_ZERO_PAD_EN
  localparam int NV  = ROW;
  localparam int NEN = ROW + 2 + 1;
`else
  localparam int NV  = ROW - TAPS + 1;
  localparam int NEN = ROW + 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic   start;
  logic   busy, done;
  state_t dbg_state;
  pe_row_feeder_if bus();

  pe_row_feeder #(.ROW_LEN(ROW), .FIFO_DEPTH(8), .PE_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_w;
  int checks = 0, errors = 0;
  int cyc = 0, en_cnt = 0, valid_cnt = 0, last_cnt = 0, done_cnt = 0;
  int first_en = -1, last_en = -1, pix_acc = 0;
  bit prev_last = 1'b0;
  bit abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      cyc++;
      if (bus.pe_en) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        if (bus.pe_psum_valid) valid_cnt++;
        if (bus.pe_psum_last) last_cnt++;
        chk("exp_queue_nonempty_on_pe_en", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          chk("pe_beat", 32'({bus.pe_filtr, bus.pe_ifmap, bus.pe_psum_valid, bus.pe_psum_last}),
              32'(exp_w));
        end
      end else begin
        chk("psum_tag_without_en", 32'({bus.pe_psum_valid, bus.pe_psum_last}), 32'd0);
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", 32'(prev_last), 32'd1);
      end
      prev_last = bus.pe_psum_last;
    end
  end

  // ---------------- expected-row model ----------------
  task automatic expect_row(input flt_word_t f, input logic [7:0] first);
    logic [7:0] pix[$];
    bit         tag[$];
    int         nv;
    bit         v, l;
`ifdef PE_FEEDER_ZERO_PAD_EN
    pix.push_back(8'h00);
`endif
    for (int i = 0; i < ROW; i++) pix.push_back(first + 8'(i));
`ifdef PE_FEEDER_ZERO_PAD_EN
    pix.push_back(8'h00);
`endif
    for (int k = 0; k < pix.size(); k++) tag.push_back(k >= TAPS - 1);
    pix.push_back(8'h00);  // one flush cycle (PE_LAT=1)
    tag.push_back(1'b0);
    nv = 0;
    for (int i = 0; i < pix.size(); i++) begin
      v = (i >= 1) && tag[i-1];  // product shows one enabled cycle later
      if (v) nv++;
      l = v && (nv == NV);
      exp_q.push_back({f, pix[i], v, l});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_filter(input flt_word_t f, input int dly);
    bit hs;
    int guard;
    repeat (dly) begin @(posedge clk); #1; end
    bus.flt_valid = 1'b1;
    bus.flt_data  = f;
    hs = 1'b0;
    guard = 0;
    while (!hs && !abort && guard < 200) begin
      @(negedge clk); hs = bus.flt_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!abort) chk("flt_handshake_in_time", 32'(hs), 32'd1);
    bus.flt_valid = 1'b0;
    bus.flt_data  = '0;
  endtask

  task automatic send_pixels(input logic [7:0] first, input int n, input bit gap);
    bit hs;
    int guard;
    for (int i = 0; i < n && !abort; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = first + 8'(i);
      hs = 1'b0;
      guard = 0;
      while (!hs && !abort && guard < 200) begin
        @(negedge clk); hs = bus.pix_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!abort) chk("pix_handshake_in_time", 32'(hs), 32'd1);
      if (hs) pix_acc++;
      bus.pix_valid = 1'b0;
      bus.pix_data  = '0;
      if (gap) begin @(posedge clk); #1; end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'({busy, done, bus.flt_ready, bus.pix_ready, bus.pe_en, bus.pe_psum_valid,
                   bus.pe_psum_last, bus.pe_filtr, bus.pe_ifmap}), 32'd0);
    chk({name, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic wait_done(input int d0);
    int g = 0;
    while (done_cnt == d0 && g < 400) begin @(negedge clk); g++; end
    chk("done_pulse_seen", 32'(done_cnt), 32'(d0 + 1));
    repeat (4) @(negedge clk);
    chk("single_done_pulse", 32'(done_cnt), 32'(d0 + 1));
    chk("idle_after_row", 32'({busy, dbg_state}), 32'(IDLE));
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("valid_count", 32'(valid_cnt), 32'(NV));
    chk("last_count", 32'(last_cnt), 32'd1);
    chk("pe_en_count", 32'(en_cnt), 32'(NEN));
  endtask

  task automatic run_row(input flt_word_t f, input logic [7:0] first, input int fdly,
                         input bit gap, input bit bp_chk, input bit mid_start);
    int d0;
    expect_row(f, first);
    en_cnt = 0; valid_cnt = 0; last_cnt = 0;
    first_en = -1; last_en = -1; pix_acc = 0;
    d0 = done_cnt;
    do_start();
    fork
      send_filter(f, fdly);
      send_pixels(first, ROW, gap);
      begin
        if (bp_chk) begin
          repeat (15) @(posedge clk);
          @(negedge clk);
          chk("bp_ready_low_after_8", 32'({bus.pix_ready, bus.flt_ready}), 32'b01);
          chk("bp_accepted_8", 32'(pix_acc), 32'd8);
        end
      end
      begin
        if (mid_start) begin
          repeat (8) @(posedge clk);
          #1;
          chk("mid_start_in_stream", 32'(dbg_state), 32'(STREAM));
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    join
    wait_done(d0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int d0, g;
    rst_n = 1'b0;
    start = 1'b0;
    bus.flt_valid = 1'b0;
    bus.flt_data  = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_values");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("idle_after_reset");

    // 1: basic row, continuous pixels
    run_row(12'h321, 8'h01, 0, 1'b0, 1'b0, 1'b0);
    chk("basic_pe_en_contiguous", 32'(last_en - first_en + 1), 32'(NEN));

    // 2: upstream bubbles
    run_row(12'h5A7, 8'h21, 0, 1'b1, 1'b0, 1'b0);
    chk("bubbles_pe_en_stalled", 32'((last_en - first_en + 1) > NEN), 32'd1);

    // 3: backpressure during a long LOAD_FLT
    run_row(12'hF0C, 8'h41, 20, 1'b0, 1'b1, 1'b0);

    // 4: start while busy
    run_row(12'h123, 8'h61, 0, 1'b0, 1'b0, 1'b1);

    // 5: reset after 5 enabled PE cycles
    expect_row(12'h999, 8'h81);
    en_cnt = 0; d0 = done_cnt;
    do_start();
    fork
      send_filter(12'h999, 0);
      send_pixels(8'h81, ROW, 1'b0);
      begin
        g = 0;
        while (en_cnt < 5 && g < 200) begin @(negedge clk); g++; end
        chk("reset_trigger_reached", 32'(en_cnt >= 5), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        chk_all_zero("reset_mid_row");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
    run_row(12'h6E2, 8'hA1, 0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pe_row_feeder.md
Name: pe_row_feeder

Overview:
- Transmit side of the PE ifmap/filter interface.
- Accepts one 3-tap filter word and a row of 8-bit pixels from upstream valid/ready streams.
- Drives one PE's weight, pixel-shift and enable inputs, one pixel per enabled cycle.
- Emits a valid/last tag aligned with the PE's Psum output, so the downstream psum collector knows which cycles carry complete 3-tap window results.

Parameters:
- ROW_LEN, 16: pixels per row; legal range TAPS..255.
- PIX_W, 8: pixel width.
- WGT_W, 4: per-tap weight width.
- TAPS, 3: taps per filter word; fixed by the PE and checked by an elaboration assertion.
- FIFO_DEPTH, 8: pixel FIFO entries; power of 2, at least 2.
- PE_LAT, 1: enabled cycles from a pixel entering the PE shift register to its product appearing on Psum_out.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a row; ignored unless in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last psum tag is issued
- flt_valid  in  1  filter word valid
- flt_data  in  TAPS*WGT_W  filter word; tap0 in bits [3:0]
- flt_ready  out  1  high only in LOAD_FLT
- pix_valid  in  1  pixel valid
- pix_data  in  PIX_W  pixel
- pix_ready  out  1  FIFO not full and row pixel count not yet reached
- pe_en  out  1  PE enable
- pe_filtr  out  TAPS*WGT_W  PE filter input
- pe_ifmap  out  PIX_W  PE pixel shift input
- pe_psum_valid  out  1  PE Psum output holds a complete window this cycle
- pe_psum_last  out  1  qualifies the final valid psum of the row

Behaviour:
- Reset values: state IDLE; FIFO empty; all counters 0; every output 0.
- Clock and reset: one clock; reset is asynchronous, active-low (rst_n) and deasserts synchronously.
- IDLE -> LOAD_FLT on start.
- LOAD_FLT: flt_ready=1. When flt_valid is seen, register flt_data into pe_filtr and go to STREAM. pe_filtr then holds until the next LOAD_FLT capture.
- Pixel accept: pix_ready is asserted in LOAD_FLT and STREAM while the FIFO is not full and accepted pixels < ROW_LEN. A transfer occurs when pix_valid and pix_ready are both high. Prefetch during LOAD_FLT is allowed.
- STREAM, FIFO non-empty: pop the FIFO head onto pe_ifmap (registered), set pe_en=1 and increment sent_cnt.
- STREAM, FIFO empty: pe_en=0 and pe_ifmap holds. The PE pipeline freezes, so stalls are lossless.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- STREAM -> DRAIN after pixel ROW_LEN-1 is sent.
- DRAIN: drive PE_LAT cycles with pe_en=1 and pe_ifmap=0 to flush the multiplier stage, then go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Tag pipeline: a PE_LAT+1 deep shift register advances only on pe_en cycles. The tag entering with pixel index k is 1 when k >= TAPS-1.
- pe_psum_valid = tag at the output stage AND pe_en is registered alongside. Exactly ROW_LEN-TAPS+1 valid cycles occur per row.
- pe_psum_last: asserted with the (ROW_LEN-TAPS+1)th valid.
- start while busy: ignored.
- Reset mid-row: FIFO is flushed, tags cleared, no done pulse.
- Counters are 8 bits wide; they do not wrap because ROW_LEN <= 255.

Optional Feature:
- Macro: PE_FEEDER_ZERO_PAD_EN.
- Defined: one zero pixel is injected before the first and after the last row pixel, without consuming the FIFO. The PE sees ROW_LEN+2 pixels and exactly ROW_LEN valid psums are tagged ("same" padding).
- Undefined: no padding; ROW_LEN-TAPS+1 valid psums ("valid" convolution).

Decomposition:
- Shared package pe_pkg:
  - PIX_W, WGT_W, TAPS, PSUM_W=14 constants.
  - Filter word typedef.
  - State enum {IDLE, LOAD_FLT, STREAM, DRAIN, FIN}.
- One sub-module, pe_feed_fifo: synchronous FIFO, FIFO_DEPTH x PIX_W, with full/empty flags and first-word-fall-through output.

Test Plan:
1. Basic row: flt_data=12'h321, pixels 1..16 continuously valid -> pe_en high 16+1 cycles; pe_ifmap sequence 1..16,0; exactly 14 pe_psum_valid cycles; last on the 14th; done one cycle later; pe_filtr=12'h321 throughout.
2. Upstream bubbles: pix_valid toggled every other cycle -> pe_en drops on empty-FIFO cycles; tag count still 14; pe_ifmap order unchanged.
3. Backpressure: pixels pushed during LOAD_FLT with flt_valid delayed 20 cycles -> pix_ready deasserts after 8 accepts; no pixel lost or duplicated.
4. Start while busy: start pulsed mid-STREAM -> ignored; single done pulse.
5. Reset mid-row: rst_n low after 5 pixels sent -> all outputs 0 immediately; new row after restart yields 14 valids with no stale tags.
6. With PE_FEEDER_ZERO_PAD_EN defined: same stimulus as scenario 1 -> pe_ifmap 0,1..16,0,... and exactly 16 valids.
